scan_chain_ctrl: RTL and testbench

Serial scan controller for the unfolded CPU netlist. It drives the pseudo-primary inputs (PPIs), the former flip-flop outputs, from a serially loaded scan register. It captures the pseudo-primary outputs (PPOs), the former flip-flop inputs, back into the same register for serial unload. It sits between the external tester pins (scan_in/scan_out/start) and the 56 PPI/PPO pairs of the CPU combinational core, replacing per-wire tester access with a single scan chain.

---
 rtl/scan_chain_ctrl_if.sv | 26 ++
 rtl/scan_chain_ctrl.sv | 144 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Tester-side bundle for scan_chain_ctrl: control pins, the serial pins, the
// PPI/PPO vectors to and from the combinational core, and the status outputs.
// The tester (or bench) uses the master modport; the controller uses slave.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 56
);
    logic                 test_mode;
    logic                 start;
    logic                 scan_in;
    logic                 scan_out;
    logic [CHAIN_LEN-1:0] ppo;
    logic [CHAIN_LEN-1:0] ppi;
    logic                 busy;
    logic                 done;
    logic [15:0]          signature;

    modport master (
        output test_mode, start, scan_in, ppo,
        input  scan_out, ppi, busy, done, signature
    );

    modport slave (
        input  test_mode, start, scan_in, ppo,
        output scan_out, ppi, busy, done, signature
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Serial scan controller for the unfolded CPU netlist.
// One sequence is SHIFT (CHAIN_LEN cycles), APPLY, CAPTURE, then a done pulse.
// A new vector is shifted in LSB first while the previous response leaves on
// scan_out. APPLY drives the vector onto the PPIs, and CAPTURE loads the PPOs
// back into the same register one cycle later.
// Optional feature: define SCAN_MISR_EN to compress the scan_out stream into
// a 16-bit MISR (x^16+x^12+x^5+1). Without it, signature is tied to zero.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 56,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_chain_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_APPLY,
        ST_CAPTURE
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] ppi_q,   ppi_d;
    logic                 done_q,  done_d;

    // Next-state and datapath decode; an abort overrides whatever the state asked for.
    always_comb begin
        // NOTE: every variable gets a hold/default value before the case so
        // that no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        ppi_d   = ppi_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && bus.test_mode) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                end
            end
            ST_SHIFT: begin
                shift_d = {bus.scan_in, shift_q[CHAIN_LEN-1:1]};
                if (count_q == LAST_IDX) begin
                    state_d = ST_APPLY;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                ppi_d   = shift_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                shift_d = bus.ppo;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Dropping test_mode mid-sequence freezes the data registers and
        // returns to IDLE without a done pulse.
        if (state_q != ST_IDLE && !bus.test_mode) begin
            state_d = ST_IDLE;
            count_d = '0;
            shift_d = shift_q;
            ppi_d   = ppi_q;
            done_d  = 1'b0;
        end
    end

    // Control and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            shift_q <= '0;
            ppi_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            ppi_q   <= ppi_d;
            done_q  <= done_d;
        end
    end

    assign bus.scan_out = shift_q[0];
    assign bus.ppi      = ppi_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;

`ifdef SCAN_MISR_EN
    logic [15:0] sig_q, sig_d;
    logic        seq_cmpl_q, seq_cmpl_d;

    // MISR next state: cleared when a new sequence follows a completed one,
    // stepped once for each bit that actually leaves on scan_out.
    always_comb begin
        sig_d      = sig_q;
        seq_cmpl_d = seq_cmpl_q;
        if (state_q == ST_IDLE && state_d == ST_SHIFT) begin
            seq_cmpl_d = 1'b0;
            if (seq_cmpl_q) begin
                sig_d = '0;
            end
        end else if (state_q == ST_SHIFT && bus.test_mode) begin
            sig_d = {sig_q[14:0], 1'b0} ^ ({16{sig_q[15] ^ shift_q[0]}} & 16'h1021);
        end
        if (done_d) begin
            seq_cmpl_d = 1'b1;
        end
    end

    // MISR registers; an aborted sequence leaves seq_cmpl low so the
    // signature keeps accumulating into the restarted sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q      <= '0;
            seq_cmpl_q <= 1'b1;
        end else begin
            sig_q      <= sig_d;
            seq_cmpl_q <= seq_cmpl_d;
        end
    end

    assign bus.signature = sig_q;
`else
    assign bus.signature = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl. An 8-cell instance covers
// load/apply, capture/unload, abort and asynchronous reset; a 56-cell instance
// covers back-to-back sequences with start held high. Every expected done
// event is queued by the stimulus and checked by a monitor at the done pulse.
module tb_scan_chain_ctrl;

    logic clk;
    logic rst_n;

    scan_chain_ctrl_if #(.CHAIN_LEN(8))  s8 ();
    scan_chain_ctrl_if #(.CHAIN_LEN(56)) s56 ();

    scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(3)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s8)
    );

    scan_chain_ctrl #(.CHAIN_LEN(56), .CNT_W(6)) u_dut56 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s56)
    );

    typedef struct {
        logic [55:0] ppi;
        logic [15:0] sig;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q56[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] m8_sig,  m56_sig;
    logic        m8_cmpl, m56_cmpl;
    logic [7:0]  exp_ppi8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
        return {s[14:0], 1'b0} ^ ({16{s[15] ^ b}} & 16'h1021);
    endfunction

    function automatic logic [15:0] exp_sig(input logic [15:0] model);
`ifdef SCAN_MISR_EN
        return model;
`else
        return 16'h0000 & model;
`endif
    endfunction

    // Monitors: each done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && s8.done) begin
            if (q8.size() == 0) begin
                check("done8_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("done8_ppi", s8.ppi, e.ppi);
                check("done8_sig", s8.signature, e.sig);
                check("done8_cycle", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s56.done) begin
            if (q56.size() == 0) begin
                check("done56_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = q56.pop_front();
                check("done56_ppi", s56.ppi, e.ppi);
                check("done56_sig", s56.signature, e.sig);
                check("done56_cycle", cyc, e.cyc);
            end
        end
    end

    // One SHIFT cycle on the 8-cell instance: drive scan_in, check the
    // outgoing response bit, advance the MISR model.
    task automatic shift8_bit(input logic b, input logic exp_so);
        s8.scan_in = b;
        @(negedge clk);
        check("scan_out8", s8.scan_out, exp_so);
        check("busy8_shift", s8.busy, 1);
        m8_sig = misr_step(m8_sig, exp_so);
        @(posedge clk); #1;
    endtask

    // Start accepted at the next edge; call with inputs driven #1 after an edge.
    task automatic start8(input logic [7:0] ppo_v, output int t_cyc);
        s8.ppo   = ppo_v;
        s8.start = 1'b1;
        @(posedge clk); #1;
        s8.start = 1'b0;
        t_cyc    = cyc;
        if (m8_cmpl) m8_sig = 16'h0000;
        m8_cmpl  = 1'b0;
    endtask

    // Full sequence on the 8-cell instance.
    task automatic seq8(input logic [7:0] vec, input logic [7:0] ppo_v, input logic [7:0] resp);
        int   t;
        exp_t e;
        start8(ppo_v, t);
        for (int k = 0; k < 8; k++) shift8_bit(vec[k], resp[k]);
        e.ppi = {48'h0, vec};
        e.sig = exp_sig(m8_sig);
        e.cyc = t + 10;
        q8.push_back(e);
        @(negedge clk);                          // APPLY
        check("busy8_apply", s8.busy, 1);
        check("ppi8_hold_apply", s8.ppi, exp_ppi8);
        @(posedge clk); #1;
        @(negedge clk);                          // CAPTURE
        check("busy8_capture", s8.busy, 1);
        check("ppi8_new", s8.ppi, vec);
        @(posedge clk); #1;
        @(negedge clk);                          // IDLE with done
        check("busy8_done_cycle", s8.busy, 0);
        exp_ppi8 = vec;
        m8_cmpl  = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [55:0] vec56 [3];
        logic [55:0] ppo56 [3];
        logic [55:0] resp56;
        logic [7:0]  vab;
        logic [7:0]  prev_resp;
        int          t;
        exp_t        e;

        vec56[0] = 56'h01_2345_6789_ABCD;
        vec56[1] = 56'hFE_DCBA_9876_5432;
        vec56[2] = 56'h80_0000_0000_0001;
        ppo56[0] = 56'h00_0000_0000_0001;
        ppo56[1] = 56'h00_0000_0000_0000;
        ppo56[2] = 56'hDE_ADBE_EFCA_FE12;

        m8_sig = '0;  m8_cmpl = 1'b1;  exp_ppi8 = '0;
        m56_sig = '0; m56_cmpl = 1'b1;

        rst_n = 1'b0;
        s8.test_mode = 1'b1;  s8.start = 1'b0;  s8.scan_in = 1'b0;  s8.ppo = '0;
        s56.test_mode = 1'b1; s56.start = 1'b0; s56.scan_in = 1'b0; s56.ppo = '0;
        #12;
        check("rst_busy", s8.busy, 0);
        check("rst_done", s8.done, 0);
        check("rst_ppi", s8.ppi, 0);
        check("rst_scan_out", s8.scan_out, 0);
        check("rst_sig", s8.signature, 0);
        check("rst56_ppi", s56.ppi, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Load/apply from reset (response all zero), then unload of 8'h3C.
        seq8(8'hA5, 8'h3C, 8'h00);
        seq8(8'h5A, 8'h81, 8'h3C);

        // Abort after 4 SHIFT cycles: register becomes {4'h3, 4'h8} = 8'h38.
        vab       = 8'hC3;
        prev_resp = 8'h81;
        start8(8'h00, t);
        for (int k = 0; k < 4; k++) shift8_bit(vab[k], prev_resp[k]);
        s8.test_mode = 1'b0;
        s8.scan_in   = 1'b1;
        @(negedge clk);
        check("busy8_abort_cycle", s8.busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("busy8_after_abort", s8.busy, 0);
        check("ppi8_after_abort", s8.ppi, 8'h5A);
        check("scan_out8_after_abort", s8.scan_out, 0);
        check("sig8_after_abort", s8.signature, exp_sig(m8_sig));
        s8.test_mode = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Fresh start restarts the count; response is the frozen 8'h38.
        seq8(8'h96, 8'h7E, 8'h38);

        // Asynchronous reset in the middle of SHIFT.
        start8(8'h00, t);
        for (int k = 0; k < 3; k++) shift8_bit(1'b1, (k == 1 || k == 2 || k == 3) ? 1'b1 : 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ppi", s8.ppi, 0);
        check("rst_mid_scan_out", s8.scan_out, 0);
        check("rst_mid_busy", s8.busy, 0);
        check("rst_mid_done", s8.done, 0);
        check("rst_mid_sig", s8.signature, 0);
        m8_sig = '0; m8_cmpl = 1'b1; exp_ppi8 = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("busy8_after_reset", s8.busy, 0);
        @(posedge clk); #1;
        seq8(8'h0F, 8'h00, 8'h00);

        // Back-to-back on the 56-cell instance with start held high.
        s56.start = 1'b1;
        @(posedge clk); #1;
        for (int v = 0; v < 3; v++) begin
            t = cyc;
            s56.ppo = ppo56[v];
            resp56 = (v == 0) ? 56'h0 : ppo56[v-1];
            if (m56_cmpl) m56_sig = 16'h0000;
            m56_cmpl = 1'b0;
            for (int k = 0; k < 56; k++) begin
                s56.scan_in = vec56[v][k];
                @(negedge clk);
                check("scan_out56", s56.scan_out, resp56[k]);
                m56_sig = misr_step(m56_sig, resp56[k]);
                @(posedge clk); #1;
            end
            e.ppi = vec56[v];
            e.sig = exp_sig(m56_sig);
            e.cyc = t + 58;
            q56.push_back(e);
            m56_cmpl = 1'b1;
            @(posedge clk); #1;                  // into CAPTURE
            if (v == 2) s56.start = 1'b0;
            @(posedge clk); #1;                  // into IDLE with done
            @(posedge clk); #1;                  // next start edge
        end
        @(negedge clk);
        check("busy56_end", s56.busy, 0);

        repeat (5) @(posedge clk);
        check("q8_drained", q8.size(), 0);
        check("q56_drained", q56.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
